// File: rtl/requantize_pipeline.sv
// rtl/requantize_pipeline.sv - scale ROM consumer and 3-stage int32 -> int8 requantizer
module requantize_pipeline #(
   parameter int NUM_LAYERS  = 6,
   parameter int MULT_WIDTH  = 32,
   parameter int SHIFT_WIDTH = 6,
   parameter int ACC_WIDTH   = 32,
   parameter int LIDX_W      = $clog2(NUM_LAYERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   layer_start,
   input  logic [LIDX_W-1:0]      layer_idx_in,
   output logic                   rom_valid,
   output logic [LIDX_W-1:0]      rom_layer_idx,
   input  logic [MULT_WIDTH-1:0]  rom_mult,
   input  logic [SHIFT_WIDTH-1:0] rom_shift,
   input  logic [7:0]             out_zero_point,
   input  logic [7:0]             act_min,
   input  logic [7:0]             act_max,
   input  logic                   acc_valid,
   input  logic [ACC_WIDTH-1:0]   acc_in,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   output logic                   params_ready,
   output logic                   err_bad_layer
);
   localparam logic signed [63:0] I32_MAX   = 64'sh0000_0000_7FFF_FFFF;
   localparam logic signed [63:0] I32_MIN   = 64'shFFFF_FFFF_8000_0000;
   localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
   localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

   typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_REQ, S_CAPTURE, S_RUN} state_t;

   state_t                   state_q, state_d;
   logic [LIDX_W-1:0]        pend_idx_q, pend_idx_d;
   logic [MULT_WIDTH-1:0]    mult_reg_q, mult_reg_d;
   logic [SHIFT_WIDTH-1:0]   shift_reg_q, shift_reg_d;
   logic                     rom_valid_q, rom_valid_d;
   logic [LIDX_W-1:0]        rom_layer_idx_q, rom_layer_idx_d;
   logic                     in_ready_q, in_ready_d;
   logic                     params_ready_q, params_ready_d;
   logic                     err_bad_layer_q, err_bad_layer_d;
   logic                     v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
   logic [31:0]              x1_q, x1_d, h2_q, h2_d;
   logic [SHIFT_WIDTH-1:0]   r1_q, r1_d, r2_q, r2_d;
   logic [7:0]               out_data_q, out_data_d;

   logic                     accept, layer_ok, pipe_busy;
   logic [SHIFT_WIDTH-1:0]   l_amt;
   logic signed [63:0]       acc_w, acc_sh, x_w, m_w, ab, sum;
   logic signed [63:0]       h_w, rnd, v, zp_w, min_w, max_w;
   logic [63:0]              mask, rem, thr;

   assign accept    = acc_valid && in_ready_q;
   assign layer_ok  = (32'(layer_idx_in) < NUM_LAYERS);
   assign pipe_busy = v1_q || v2_q || out_valid_q;

   always_comb begin
      state_d         = state_q;
      pend_idx_d      = pend_idx_q;
      mult_reg_d      = mult_reg_q;
      shift_reg_d     = shift_reg_q;
      err_bad_layer_d = 1'b0;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (layer_start) begin
               if (!layer_ok) begin
                  err_bad_layer_d = 1'b1;
               end else begin
                  pend_idx_d = layer_idx_in;
                  // an element accepted this very cycle still counts as in flight
                  state_d    = (pipe_busy || accept) ? S_DRAIN : S_REQ;
               end
            end
         end
         S_DRAIN:   if (!pipe_busy) state_d = S_REQ;
         S_REQ:     state_d = S_CAPTURE;
         S_CAPTURE: begin
            mult_reg_d  = rom_mult;
            shift_reg_d = rom_shift;
            state_d     = S_RUN;
         end
         default:   state_d = S_IDLE;
      endcase
      rom_valid_d     = (state_d == S_REQ);
      rom_layer_idx_d = (state_d == S_REQ) ? pend_idx_d : '0;
      in_ready_d      = (state_d == S_RUN);
      params_ready_d  = (state_d == S_RUN);
   end

   always_comb begin
      l_amt = shift_reg_q[SHIFT_WIDTH-1] ? '0 : shift_reg_q;
      r1_d  = shift_reg_q[SHIFT_WIDTH-1] ? SHIFT_WIDTH'(-shift_reg_q) : '0;
      acc_w  = {{(64-ACC_WIDTH){acc_in[ACC_WIDTH-1]}}, acc_in};
      acc_sh = acc_w <<< l_amt;
      if (acc_sh > I32_MAX)      x1_d = 32'h7FFF_FFFF;
      else if (acc_sh < I32_MIN) x1_d = 32'h8000_0000;
      else                       x1_d = acc_sh[31:0];

      // rounding doubling high multiply; divide by 2^31 truncates toward zero
      x_w = {{32{x1_q[31]}}, x1_q};
      m_w = {{(64-MULT_WIDTH){mult_reg_q[MULT_WIDTH-1]}}, mult_reg_q};
      ab  = x_w * m_w;
      sum = ab + (ab[63] ? NUDGE_NEG : NUDGE_POS);
      if (x1_q == 32'h8000_0000 && mult_reg_q == {1'b1, {(MULT_WIDTH-1){1'b0}}})
         h2_d = 32'h7FFF_FFFF;
      else
         h2_d = sum[62:31] + {31'd0, (sum[63] && (sum[30:0] != 31'd0))};
      r2_d = r1_q;

      h_w   = {{32{h2_q[31]}}, h2_q};
      mask  = (64'd1 << r2_q) - 64'd1;
      rem   = h_w & mask;
      thr   = (mask >> 1) + {63'd0, h2_q[31]};
      rnd   = (h_w >>> r2_q) + ((rem > thr) ? 64'sd1 : 64'sd0);
      zp_w  = {{56{out_zero_point[7]}}, out_zero_point};
      min_w = {{56{act_min[7]}}, act_min};
      max_w = {{56{act_max[7]}}, act_max};
      v     = rnd + zp_w;
      if (v < min_w)      out_data_d = act_min;
      else if (v > max_w) out_data_d = act_max;
      else                out_data_d = v[7:0];

      v1_d        = accept;
      v2_d        = v1_q;
      out_valid_d = v2_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         pend_idx_q      <= '0;
         mult_reg_q      <= '0;
         shift_reg_q     <= '0;
         rom_valid_q     <= 1'b0;
         rom_layer_idx_q <= '0;
         in_ready_q      <= 1'b0;
         params_ready_q  <= 1'b0;
         err_bad_layer_q <= 1'b0;
         v1_q            <= 1'b0;
         v2_q            <= 1'b0;
         out_valid_q     <= 1'b0;
         x1_q            <= '0;
         h2_q            <= '0;
         r1_q            <= '0;
         r2_q            <= '0;
         out_data_q      <= '0;
      end else begin
         state_q         <= state_d;
         pend_idx_q      <= pend_idx_d;
         mult_reg_q      <= mult_reg_d;
         shift_reg_q     <= shift_reg_d;
         rom_valid_q     <= rom_valid_d;
         rom_layer_idx_q <= rom_layer_idx_d;
         in_ready_q      <= in_ready_d;
         params_ready_q  <= params_ready_d;
         err_bad_layer_q <= err_bad_layer_d;
         v1_q            <= v1_d;
         v2_q            <= v2_d;
         out_valid_q     <= out_valid_d;
         x1_q            <= x1_d;
         h2_q            <= h2_d;
         r1_q            <= r1_d;
         r2_q            <= r2_d;
         out_data_q      <= out_data_d;
      end
   end

   assign rom_valid     = rom_valid_q;
   assign rom_layer_idx = rom_layer_idx_q;
   assign in_ready      = in_ready_q;
   assign params_ready  = params_ready_q;
   assign err_bad_layer = err_bad_layer_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
endmodule

// File: doc/requantize_pipeline.md
Name: requantize_pipeline

Overview:
Consumer end of the requantize scale ROM interface. On a layer switch it issues a one-cycle read (valid plus layer index) and captures the returned per-layer multiplier and shift. It then streams int32 accumulators through a 3-stage fixed-point requantizer (rounding doubling high-multiply, rounding right shift, zero-point add, int8 clamp). It sits between the systolic array accumulators and the activation writeback.

Parameters:
NUM_LAYERS, 6, number of ROM entries; layer index width LIDX_W = $clog2(NUM_LAYERS)
MULT_WIDTH, 32, ROM multiplier width (signed Q0.31)
SHIFT_WIDTH, 6, ROM shift width (signed; positive = left shift, negative = right shift)
ACC_WIDTH, 32, accumulator input width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
layer_start  in  1  single-cycle request to load params for layer_idx_in
layer_idx_in  in  LIDX_W  requested layer
rom_valid  out  1  read strobe to the scale ROM
rom_layer_idx  out  LIDX_W  ROM address
rom_mult  in  MULT_WIDTH  ROM multiplier; valid the cycle after rom_valid
rom_shift  in  SHIFT_WIDTH  ROM shift; valid the cycle after rom_valid
out_zero_point  in  8  signed output zero point; held static while RUN
act_min, act_max  in  8 each  signed clamp bounds; act_min <= act_max
acc_valid  in  1  accumulator valid
acc_in  in  ACC_WIDTH  signed accumulator
in_ready  out  1  high only in RUN; acc_valid is ignored when low
out_valid  out  1  result valid, one cycle per accepted input
out_data  out  8  signed int8 result
params_ready  out  1  high in RUN
err_bad_layer  out  1  one-cycle pulse on a rejected layer_start

Behaviour:
- Reset: state = IDLE; rom_valid, rom_layer_idx, in_ready, out_valid, out_data, params_ready, err_bad_layer, mult_reg, shift_reg and all pipeline valids = 0.
- States: IDLE, DRAIN, REQ, CAPTURE, RUN.
- IDLE/RUN + layer_start:
  - If layer_idx_in >= NUM_LAYERS: pulse err_bad_layer next cycle. State and params are unchanged.
  - Otherwise latch pend_idx. Go to REQ if pipeline is empty, else DRAIN. Drop in_ready the next cycle.
- DRAIN: in_ready = 0; go to REQ when all three stage valids are 0. In-flight data completes using the old params.
- REQ: rom_valid = 1 and rom_layer_idx = pend_idx for exactly one cycle; next state CAPTURE.
- CAPTURE: mult_reg <= rom_mult, shift_reg <= rom_shift; next state RUN. The ROM returns 0 when not strobed, so capture happens only in this state.
- Switch timing: layer_start in IDLE at cycle T -> rom_valid at T+1 -> params_ready = in_ready = 1 at T+3.
- layer_start arriving during DRAIN/REQ/CAPTURE is ignored (no error pulse).
- Pipeline, per accepted element (acc_valid && in_ready), latency 3 cycles, throughput 1 per cycle, no output backpressure:
  - S1: L = max(shift,0), R = max(-shift,0). x = acc << L, saturated to int32 range.
  - S2: if x == mult == INT32_MIN, h = INT32_MAX. Else ab = x*mult (64-bit signed); nudge = (ab >= 0) ? 2^30 : 1 - 2^30; h = (ab + nudge) / 2^31, truncating toward zero.
  - S3: mask = 2^R - 1; rem = h & mask; thr = (mask >> 1) + (h < 0); r = (h >>> R) + (rem > thr). R >= 31 gives r = 0 or -1 by the same formula with 64-bit intermediates. v = r + out_zero_point, widened before adding. Clamp v to [act_min, act_max] giving out_data.
  - out_valid asserts 3 cycles after acceptance. Gaps in acc_valid produce matching gaps in out_valid.
- Reset mid-operation flushes the pipeline (all valids 0) and returns to IDLE. Params are lost; a new layer_start is required.

Test Plan:
1. Reset, then layer_start idx=2 with ROM[2] = {mult 0x40000000, shift 0} -> rom_valid one cycle at T+1 with rom_layer_idx=2; params_ready at T+3; rom_valid never reasserts.
2. zp=-128, min=-128, max=127; acc=100 -> out_data=-78 three cycles later. acc=-100 -> -128 (clamp from -178).
3. mult 0x40000000, shift -2, zp 0; back-to-back acc=1000, 1002, 1006 -> 125, 125, 126 on consecutive cycles.
4. mult 0x7FFFFFFF, shift 1, acc=0x7FFFFFFF -> left-shift saturation -> 127. acc=INT32_MIN with mult=INT32_MIN, shift 0 -> 127.
5. Stream 5 elements, then layer_start on the cycle after the last acceptance -> DRAIN; the 5 outputs use the old params; rom_valid asserts only after the pipeline empties; in_ready stays low throughout.
6. layer_start with idx=6 (NUM_LAYERS=6) -> err_bad_layer pulse, no rom_valid, params unchanged. Reset asserted mid-stream -> out_valid 0 next cycle, state IDLE.
